// File: rtl/data_sync_sender.sv
// Source-domain transmitter for a multi-bit bus synchronizer: each word is held stable on the
// bus while a HIGH/LOW enable level frames it, with a one-entry pending slot toward upstream.
module data_sync_sender #(
  parameter int BUS_WIDTH   = 8,
  parameter int HIGH_CYCLES = 4,
  parameter int LOW_CYCLES  = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 data_valid_in,
  input  logic [BUS_WIDTH-1:0] data_in,
  output logic                 data_ready_out,
  output logic [BUS_WIDTH-1:0] unsync_data_out,
  output logic                 bus_enable_out,
  output logic                 busy_out
);

  localparam int MAX_CYCLES = (HIGH_CYCLES > LOW_CYCLES) ? HIGH_CYCLES : LOW_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  localparam logic [CNT_W-1:0] HIGH_LOAD = CNT_W'(HIGH_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOW_LOAD  = CNT_W'(LOW_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    HIGH  = 2'd2,
    LOW   = 2'd3
  } state_t;

  state_t               state;
  state_t               state_nxt;
  logic [CNT_W-1:0]     cnt;
  logic [CNT_W-1:0]     cnt_nxt;
  logic [BUS_WIDTH-1:0] bus_data;
  logic [BUS_WIDTH-1:0] bus_data_nxt;
  logic [BUS_WIDTH-1:0] pend_data;
  logic [BUS_WIDTH-1:0] pend_data_nxt;
  logic                 pend_valid;
  logic                 pend_valid_nxt;
  logic                 enable;
  logic                 enable_nxt;
  logic                 busy;
  logic                 busy_nxt;
  logic                 accept;
  logic                 pend_load;
  logic                 cnt_done;

  assign accept          = data_valid_in & ~pend_valid;
  assign cnt_done        = (cnt == CNT_ZERO);
  assign data_ready_out  = ~pend_valid;
  assign unsync_data_out = bus_data;
  assign bus_enable_out  = enable;
  assign busy_out        = busy;

  // Next-state, counter, bus and pending-slot decisions for one source clock.
  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    bus_data_nxt   = bus_data;
    enable_nxt     = enable;
    pend_valid_nxt = pend_valid;
    pend_data_nxt  = pend_data;
    pend_load      = 1'b0;

    case (state)
      IDLE: begin
        enable_nxt = 1'b0;
        if (accept) begin
          bus_data_nxt = data_in;
          state_nxt    = SETUP;
        end else begin
          state_nxt    = IDLE;
        end
      end
      SETUP: begin
        enable_nxt = 1'b1;
        cnt_nxt    = HIGH_LOAD;
        state_nxt  = HIGH;
        pend_load  = accept;
      end
      HIGH: begin
        pend_load = accept;
        if (cnt_done) begin
          enable_nxt = 1'b0;
          cnt_nxt    = LOW_LOAD;
          state_nxt  = LOW;
        end else begin
          cnt_nxt    = cnt - CNT_ONE;
        end
      end
      LOW: begin
        // A word arriving on the exit edge with the slot empty goes straight to the bus.
        if (!cnt_done) begin
          cnt_nxt   = cnt - CNT_ONE;
          pend_load = accept;
        end else if (pend_valid) begin
          bus_data_nxt   = pend_data;
          pend_valid_nxt = 1'b0;
          state_nxt      = SETUP;
        end else if (accept) begin
          bus_data_nxt   = data_in;
          state_nxt      = SETUP;
        end else begin
          state_nxt      = IDLE;
        end
      end
      default: begin
        state_nxt  = IDLE;
        enable_nxt = 1'b0;
        cnt_nxt    = CNT_ZERO;
      end
    endcase

    if (pend_load) begin
      pend_data_nxt  = data_in;
      pend_valid_nxt = 1'b1;
    end else begin
      pend_data_nxt  = pend_data;
    end

    busy_nxt = (state_nxt != IDLE);
  end

  // State and output registers; reset aborts any transfer and empties the pending slot.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      cnt        <= CNT_ZERO;
      bus_data   <= {BUS_WIDTH{1'b0}};
      pend_data  <= {BUS_WIDTH{1'b0}};
      pend_valid <= 1'b0;
      enable     <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      bus_data   <= bus_data_nxt;
      pend_data  <= pend_data_nxt;
      pend_valid <= pend_valid_nxt;
      enable     <= enable_nxt;
      busy       <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_data_sync_sender.sv
// Self-checking bench for data_sync_sender: a word-timeline model checked every cycle,
// plus directed scenarios with hand-computed edge numbers and data values.
module tb_data_sync_sender;

  logic       clk     = 1'b0;
  logic       reset_n = 1'b0;
  logic       valid_a = 1'b0;
  logic [7:0] din_a   = 8'h00;
  logic       valid_b = 1'b0;
  logic [7:0] din_b   = 8'h00;
  logic       ready_a, en_a, busy_a;
  logic [7:0] data_a;
  logic       ready_b, en_b, busy_b;
  logic [7:0] data_b;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  int         acc_q[$];
  int         rise_a[$];
  logic [7:0] rdat_a[$];
  int         rise_b[$];
  logic [7:0] rdat_b[$];
  logic       en_a_prev = 1'b0;
  logic       en_b_prev = 1'b0;
  logic [7:0] words [4];

  // Timeline model: a word in flight started k edges ago; index 0 is 4/4, index 1 is 1/1.
  bit         m_active [2];
  int         m_k      [2];
  logic [7:0] m_data   [2];
  bit         m_pv     [2];
  logic [7:0] m_pd     [2];

  data_sync_sender #(.BUS_WIDTH(8), .HIGH_CYCLES(4), .LOW_CYCLES(4)) dut_a (
    .clk(clk), .reset_n(reset_n), .data_valid_in(valid_a), .data_in(din_a),
    .data_ready_out(ready_a), .unsync_data_out(data_a), .bus_enable_out(en_a), .busy_out(busy_a)
  );

  data_sync_sender #(.BUS_WIDTH(8), .HIGH_CYCLES(1), .LOW_CYCLES(1)) dut_b (
    .clk(clk), .reset_n(reset_n), .data_valid_in(valid_b), .data_in(din_b),
    .data_ready_out(ready_b), .unsync_data_out(data_b), .bus_enable_out(en_b), .busy_out(busy_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 2; i++) begin
      m_active[i] = 1'b0;
      m_k[i]      = 0;
      m_data[i]   = 8'h00;
      m_pv[i]     = 1'b0;
      m_pd[i]     = 8'h00;
    end
  endfunction

  function automatic void model_step(int i, logic v, logic [7:0] d, int hc, int lc);
    bit acc;
    acc = v && !m_pv[i];
    if (m_active[i]) begin
      m_k[i] = m_k[i] + 1;
      if (m_k[i] == 1 + hc + lc) m_active[i] = 1'b0;
    end
    if (acc) begin
      m_pv[i] = 1'b1;
      m_pd[i] = d;
    end
    if (!m_active[i] && m_pv[i]) begin
      m_active[i] = 1'b1;
      m_k[i]      = 0;
      m_data[i]   = m_pd[i];
      m_pv[i]     = 1'b0;
    end
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) model_reset();
    else begin
      model_step(0, valid_a, din_a, 4, 4);
      model_step(1, valid_b, din_b, 1, 1);
    end
  end

  // Per-cycle comparison against the model, plus enable-rise logging.
  always @(negedge clk) begin
    check("a_data",  data_a,  m_data[0]);
    check("a_en",    en_a,    m_active[0] && m_k[0] >= 1 && m_k[0] <= 4);
    check("a_busy",  busy_a,  m_active[0]);
    check("a_ready", ready_a, !m_pv[0]);
    check("b_data",  data_b,  m_data[1]);
    check("b_en",    en_b,    m_active[1] && m_k[1] == 1);
    check("b_busy",  busy_b,  m_active[1]);
    check("b_ready", ready_b, !m_pv[1]);
    if (en_a && !en_a_prev) begin
      rise_a.push_back(cyc);
      rdat_a.push_back(data_a);
    end
    if (en_b && !en_b_prev) begin
      rise_b.push_back(cyc);
      rdat_b.push_back(data_b);
    end
    en_a_prev <= en_a;
    en_b_prev <= en_b;
  end

  task automatic check_reset(input string tag);
    check({tag, "_a_data"},  data_a,  32'h0);
    check({tag, "_a_en"},    en_a,    32'h0);
    check({tag, "_a_busy"},  busy_a,  32'h0);
    check({tag, "_a_ready"}, ready_a, 32'h1);
    check({tag, "_b_data"},  data_b,  32'h0);
    check({tag, "_b_en"},    en_b,    32'h0);
    check({tag, "_b_busy"},  busy_b,  32'h0);
    check({tag, "_b_ready"}, ready_b, 32'h1);
  endtask

  // Presents words[0..n-1] with valid held; logs the edge number of each accept.
  task automatic feed(input int inst, input int n);
    for (int i = 0; i < n; i++) begin
      bit acc;
      int guard;
      acc   = 1'b0;
      guard = 0;
      if (inst == 0) begin valid_a = 1'b1; din_a = words[i]; end
      else           begin valid_b = 1'b1; din_b = words[i]; end
      while (!acc && guard < 50) begin
        acc = (inst == 0) ? ready_a : ready_b;
        if (acc) acc_q.push_back(cyc + 1);
        @(negedge clk);
        guard++;
      end
      if (!acc) begin
        n_checks++;
        n_fail++;
        $display("FAIL feed_timeout: word %0d of instance %0d never accepted", i, inst);
      end
    end
    valid_a = 1'b0;
    valid_b = 1'b0;
  endtask

  initial begin
    int e0;

    // Reset with arbitrary input state, then release with valid low.
    valid_a = 1'b1;
    din_a   = 8'hFF;
    repeat (3) @(negedge clk);
    check_reset("rst_hold");
    valid_a = 1'b0;
    #2 reset_n = 1'b1;
    @(negedge clk);
    check_reset("rst_release");
    @(negedge clk);

    // Single word 0xA5.
    valid_a = 1'b1;
    din_a   = 8'hA5;
    @(negedge clk);
    valid_a = 1'b0;
    check("single_data_e0", data_a, 32'hA5);
    check("single_busy_e0", busy_a, 32'h1);
    check("single_en_e0",   en_a,   32'h0);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      check("single_en",    en_a,    (k <= 4) ? 32'h1 : 32'h0);
      check("single_busy",  busy_a,  (k < 9)  ? 32'h1 : 32'h0);
      check("single_ready", ready_a, 32'h1);
      check("single_data",  data_a,  32'hA5);
    end

    // Back-to-back 0x11, 0x22, 0x33.
    acc_q.delete(); rise_a.delete(); rdat_a.delete();
    words = '{8'h11, 8'h22, 8'h33, 8'h00};
    feed(0, 3);
    check("b2b_ready_e10", ready_a, 32'h0);
    check("b2b_data_e10",  data_a,  32'h22);
    check("b2b_en_e10",    en_a,    32'h1);
    repeat (25) @(negedge clk);
    check("b2b_accepts", acc_q.size(), 32'd3);
    check("b2b_rises",   rise_a.size(), 32'd3);
    if (acc_q.size() == 3 && rise_a.size() == 3) begin
      e0 = acc_q[0];
      check("b2b_acc1",  acc_q[1],  e0 + 1);
      check("b2b_acc2",  acc_q[2],  e0 + 10);
      check("b2b_rise0", rise_a[0], e0 + 1);
      check("b2b_rise1", rise_a[1], e0 + 10);
      check("b2b_rise2", rise_a[2], e0 + 19);
      for (int i = 0; i < 3; i++) check("b2b_order", rdat_a[i], words[i]);
    end

    // Stalled upstream: data_in changes every cycle while the pending slot is full.
    valid_a = 1'b1;
    din_a   = 8'h40;
    @(negedge clk);
    din_a = 8'h41;
    @(negedge clk);
    check("stall_pend_full", ready_a, 32'h0);
    for (int j = 1; j <= 9; j++) begin
      din_a = 8'(8'h80 + j);
      @(negedge clk);
    end
    valid_a = 1'b0;
    check("stall_data_e10",  data_a,  32'h41);
    check("stall_ready_e10", ready_a, 32'h0);
    repeat (9) @(negedge clk);
    check("stall_data_e19", data_a, 32'h89);
    repeat (10) @(negedge clk);
    check("stall_idle", busy_a, 32'h0);

    // Reset during the third HIGH cycle with 0x22 pending.
    valid_a = 1'b1;
    din_a   = 8'h77;
    @(negedge clk);
    din_a = 8'h22;
    @(negedge clk);
    valid_a = 1'b0;
    repeat (2) @(negedge clk);
    check("midrst_pending", ready_a, 32'h0);
    check("midrst_en_pre",  en_a,    32'h1);
    #2 reset_n = 1'b0;
    #1 check_reset("midrst");
    @(negedge clk);
    #2 reset_n = 1'b1;
    @(negedge clk);
    rise_a.delete(); rdat_a.delete();
    valid_a = 1'b1;
    din_a   = 8'h5A;
    @(negedge clk);
    valid_a = 1'b0;
    check("midrst_new_data", data_a, 32'h5A);
    repeat (10) @(negedge clk);
    check("midrst_done_busy", busy_a, 32'h0);
    check("midrst_done_data", data_a, 32'h5A);
    check("midrst_rises", rise_a.size(), 32'd1);
    if (rdat_a.size() == 1) check("midrst_rise_data", rdat_a[0], 32'h5A);

    // Minimum timing instance: four back-to-back words.
    acc_q.delete(); rise_b.delete(); rdat_b.delete();
    words = '{8'hC1, 8'hC2, 8'hC3, 8'hC4};
    feed(1, 4);
    repeat (8) @(negedge clk);
    check("min_rises", rise_b.size(), 32'd4);
    if (rise_b.size() == 4 && acc_q.size() == 4) begin
      check("min_first_rise", rise_b[0], acc_q[0] + 1);
      for (int i = 0; i < 3; i++) check("min_period", rise_b[i+1] - rise_b[i], 32'd3);
      for (int i = 0; i < 4; i++) check("min_order", rdat_b[i], words[i]);
    end
    check("min_idle", busy_b, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
